rs_syndrome_stream: RTL and testbench

- Streaming Reed-Solomon syndrome generator over GF(2^SYMBOL_WIDTH).
- Accepts one received codeword symbol per cycle on a valid/ready input and accumulates all NUM_SYN syndromes in parallel using Horner's rule.
- When the frame completes, presents the syndrome vector and an error-detect flag on a valid/ready output.
- Parametrised successor to the fixed-width combinational syndrome units. It sits between the receive symbol stream and the key-equation solver.

---
 rtl/rs_syndrome_stream.sv | 158 +++++++++++++++
 tb/tb_rs_syndrome_stream.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_syndrome_stream.sv
// Streaming Reed-Solomon syndrome generator over GF(2^SYMBOL_WIDTH).
// Symbols arrive highest-degree first. Each accepted symbol advances all
// NUM_SYN Horner accumulators in parallel:
//   S_j <- S_j * alpha^j + v
// A complete frame is presented with an error-detect flag on a valid/ready
// output. A frame whose in_last does not line up with the N-th symbol is
// dropped and flagged with a one-cycle frame_err pulse.
module rs_syndrome_stream #(
  parameter int                      SYMBOL_WIDTH = 8,
  parameter int                      N            = 18,
  parameter int                      NUM_SYN      = 2,
  parameter logic [SYMBOL_WIDTH:0]   PRIM_POLY    = 9'h11D,
  parameter int                      FIRST_ROOT   = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [SYMBOL_WIDTH-1:0]           in_symbol,
  input  logic                              in_last,
  output logic                              syn_valid,
  input  logic                              syn_ready,
  output logic [NUM_SYN*SYMBOL_WIDTH-1:0]   syndromes,
  output logic                              err_detect,
  output logic                              frame_err
);

  localparam int SW    = SYMBOL_WIDTH;
  localparam int CNT_W = (N > 2) ? $clog2(N) : 1;

  // Multiply by alpha (x), reducing by the primitive polynomial.
  function automatic logic [SW-1:0] gf_xtime(input logic [SW-1:0] a);
    logic [SW-1:0] r;
    r = {a[SW-2:0], 1'b0};
    if (a[SW-1]) r = r ^ PRIM_POLY[SW-1:0];
    return r;
  endfunction

  // General GF multiply. Only ever called with a constant second operand,
  // so it folds down to an XOR network.
  function automatic logic [SW-1:0] gf_mul(input logic [SW-1:0] a,
                                           input logic [SW-1:0] b);
    logic [SW-1:0] p;
    logic [SW-1:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < SW; i++) begin
      if (b[i]) p = p ^ x;
      x = gf_xtime(x);
    end
    return p;
  endfunction

  // alpha^e, evaluated at elaboration time.
  function automatic logic [SW-1:0] alpha_pow(input int e);
    logic [SW-1:0] p;
    p = {{(SW-1){1'b0}}, 1'b1};
    for (int i = 0; i < e; i++) p = gf_xtime(p);
    return p;
  endfunction

  // Packed table of the generator roots alpha^(FIRST_ROOT+k).
  function automatic logic [NUM_SYN*SW-1:0] root_table();
    logic [NUM_SYN*SW-1:0] t;
    t = '0;
    for (int k = 0; k < NUM_SYN; k++) t[k*SW +: SW] = alpha_pow(FIRST_ROOT + k);
    return t;
  endfunction

  localparam logic [NUM_SYN*SW-1:0] ROOTS = root_table();

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [SW-1:0]    acc_p1  [NUM_SYN];
  logic [SW-1:0]    acc_nxt [NUM_SYN];
  logic             any_nz;
  logic             xfer;
  logic             at_end;

  assign xfer   = in_valid && in_ready;
  assign at_end = (count == CNT_W'(N - 1));

  // Next accumulator values: the first symbol loads, later symbols go
  // through one Horner step. any_nz looks ahead at the final values.
  always_comb begin
    any_nz = 1'b0;
    for (int k = 0; k < NUM_SYN; k++) begin
      acc_nxt[k] = '0;
      if (count == '0) acc_nxt[k] = in_symbol;
      else             acc_nxt[k] = gf_mul(acc_p1[k], ROOTS[k*SW +: SW]) ^ in_symbol;
      any_nz = any_nz | (acc_nxt[k] != '0);
    end
  end

  // ---- stage p1: accumulators, doubling as the output syndrome registers
  // Accumulators only move on an input transfer. in_ready is low in HOLD,
  // so the presented syndromes stay frozen until they are consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_SYN; k++) acc_p1[k] <= '0;
    end else if (xfer) begin
      acc_p1 <= acc_nxt;
    end
  end

  for (genvar k = 0; k < NUM_SYN; k++) begin : g_out
    assign syndromes[k*SW +: SW] = acc_p1[k];
  end

  // Frame control FSM: symbol count, frame end and drop handling, output
  // handshake. All handshake outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACCUM;
      count      <= '0;
      in_ready   <= 1'b1;
      syn_valid  <= 1'b0;
      err_detect <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ACCUM: begin
          if (xfer) begin
            if (at_end && in_last) begin
              state      <= HOLD;
              count      <= '0;
              in_ready   <= 1'b0;
              syn_valid  <= 1'b1;
              err_detect <= any_nz;
            end else if (at_end || in_last) begin
              // Misaligned in_last: drop the frame and start over.
              count     <= '0;
              frame_err <= 1'b1;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (syn_ready) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            syn_valid <= 1'b0;
          end
        end
        default: begin
          state    <= ACCUM;
          count    <= '0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs_syndrome_stream.sv
// Directed bench for rs_syndrome_stream with the default GF(2^8) / 0x11D /
// N=18 / two-syndrome configuration. Inputs are driven and outputs are
// sampled on the falling edge of clk.
module tb_rs_syndrome_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_symbol;
  logic        in_last;
  logic        syn_valid;
  logic        syn_ready;
  logic [15:0] syndromes;
  logic        err_detect;
  logic        frame_err;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rs_syndrome_stream #(
    .SYMBOL_WIDTH(8), .N(18), .NUM_SYN(2), .PRIM_POLY(9'h11D), .FIRST_ROOT(1)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_symbol(in_symbol), .in_last(in_last),
    .syn_valid(syn_valid), .syn_ready(syn_ready), .syndromes(syndromes),
    .err_detect(err_detect), .frame_err(frame_err)
  );

  // Sends a frame of len symbols: first, zeros, then last_sym as the final
  // symbol. in_last marks the final symbol only when with_last is set.
  task automatic send_frame(input logic [7:0] first, input logic [7:0] last_sym,
                            input int len, input bit with_last, input bit bubbles);
    for (int i = 0; i < len; i++) begin
      int guard;
      if (bubbles) begin
        int gap;
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      end
      guard = 0;
      while (!in_ready && guard < 50) begin
        in_valid = 1'b0;
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        vectors++; miscompares++;
        $display("FAIL in_ready_timeout: in_ready=%0b required 1 at symbol %0d", in_ready, i);
      end
      in_valid  = 1'b1;
      in_symbol = (i == 0) ? first : ((i == len - 1) ? last_sym : 8'h00);
      in_last   = with_last && (i == len - 1);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_symbol = 8'h00;
  endtask

  task automatic pulse_rst();
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_symbol = 8'h00; in_last = 1'b0; syn_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({syn_valid, err_detect, frame_err, in_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_ctrl: {syn_valid,err,frame_err,in_ready}=%b required 0001",
               {syn_valid, err_detect, frame_err, in_ready});
    end
    vectors++;
    if (syndromes !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_syn: syndromes=%h required 0000", syndromes);
    end
  endtask

  task automatic test_zero_frame();
    send_frame(8'h00, 8'h00, 18, 1'b1, 1'b0);
    vectors++;
    if ({syn_valid, err_detect, in_ready, syndromes} !== {3'b100, 16'h0000}) begin
      miscompares++;
      $display("FAIL zero_frame: valid/err/ready=%b syn=%h required 100 0000",
               {syn_valid, err_detect, in_ready}, syndromes);
    end
    @(negedge clk);
    vectors++;
    if ({syn_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL zero_release: valid/ready=%b required 01", {syn_valid, in_ready});
    end
  endtask

  task automatic test_single_errors();
    send_frame(8'h00, 8'h01, 18, 1'b1, 1'b0);
    vectors++;
    if ({syn_valid, err_detect, syndromes} !== {2'b11, 16'h0101}) begin
      miscompares++;
      $display("FAIL err_v0: valid/err=%b syn=%h required 11 0101",
               {syn_valid, err_detect}, syndromes);
    end
    @(negedge clk);
    // Back-to-back: the next frame starts immediately after the handshake.
    send_frame(8'h01, 8'h00, 18, 1'b1, 1'b0);
    vectors++;
    if ({syn_valid, err_detect, syndromes} !== {2'b11, 16'h4E98}) begin
      miscompares++;
      $display("FAIL err_v17: valid/err=%b syn=%h required 11 4e98",
               {syn_valid, err_detect}, syndromes);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    syn_ready = 1'b0;
    send_frame(8'h01, 8'h01, 18, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if ({syn_valid, in_ready, err_detect, syndromes} !== {3'b101, 16'h4F99}) begin
        miscompares++;
        $display("FAIL hold_cycle%0d: valid/ready/err=%b syn=%h required 101 4f99",
                 c, {syn_valid, in_ready, err_detect}, syndromes);
      end
      in_valid  = 1'b1;
      in_symbol = 8'hFF;
      in_last   = (c == 2);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0; in_symbol = 8'h00;
    syn_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({syn_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL hold_release: valid/ready=%b required 01", {syn_valid, in_ready});
    end
    send_frame(8'h00, 8'h01, 18, 1'b1, 1'b0);
    vectors++;
    if ({syn_valid, syndromes} !== {1'b1, 16'h0101}) begin
      miscompares++;
      $display("FAIL after_hold: valid=%b syn=%h required 1 0101", syn_valid, syndromes);
    end
    @(negedge clk);
  endtask

  task automatic test_frame_err();
    send_frame(8'h00, 8'h05, 10, 1'b1, 1'b0);
    vectors++;
    if ({frame_err, syn_valid, in_ready} !== 3'b101) begin
      miscompares++;
      $display("FAIL early_last: frame_err/valid/ready=%b required 101",
               {frame_err, syn_valid, in_ready});
    end
    @(negedge clk);
    vectors++;
    if ({frame_err, syn_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL early_last_pulse: frame_err/valid=%b required 00", {frame_err, syn_valid});
    end
    send_frame(8'h00, 8'h00, 18, 1'b1, 1'b0);
    vectors++;
    if ({syn_valid, err_detect, syndromes} !== {2'b10, 16'h0000}) begin
      miscompares++;
      $display("FAIL after_early: valid/err=%b syn=%h required 10 0000",
               {syn_valid, err_detect}, syndromes);
    end
    @(negedge clk);
    send_frame(8'h03, 8'h07, 18, 1'b0, 1'b0);
    vectors++;
    if ({frame_err, syn_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL missing_last: frame_err/valid=%b required 10", {frame_err, syn_valid});
    end
    send_frame(8'h01, 8'h00, 18, 1'b1, 1'b0);
    vectors++;
    if ({syn_valid, syndromes} !== {1'b1, 16'h4E98}) begin
      miscompares++;
      $display("FAIL after_missing: valid=%b syn=%h required 1 4e98", syn_valid, syndromes);
    end
    @(negedge clk);
  endtask

  task automatic test_rst_mid();
    send_frame(8'h07, 8'h07, 9, 1'b0, 1'b0);
    pulse_rst();
    vectors++;
    if ({syn_valid, err_detect, frame_err, in_ready, syndromes} !== {4'b0001, 16'h0000}) begin
      miscompares++;
      $display("FAIL rst_mid_frame: valid/err/ferr/ready=%b syn=%h required 0001 0000",
               {syn_valid, err_detect, frame_err, in_ready}, syndromes);
    end
    syn_ready = 1'b0;
    send_frame(8'h01, 8'h00, 18, 1'b1, 1'b0);
    vectors++;
    if (syn_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre_hold: syn_valid=%b required 1", syn_valid);
    end
    @(negedge clk);
    pulse_rst();
    vectors++;
    if ({syn_valid, err_detect, frame_err, in_ready, syndromes} !== {4'b0001, 16'h0000}) begin
      miscompares++;
      $display("FAIL rst_in_hold: valid/err/ferr/ready=%b syn=%h required 0001 0000",
               {syn_valid, err_detect, frame_err, in_ready}, syndromes);
    end
    syn_ready = 1'b1;
    send_frame(8'h00, 8'h01, 18, 1'b1, 1'b0);
    vectors++;
    if ({syn_valid, err_detect, syndromes} !== {2'b11, 16'h0101}) begin
      miscompares++;
      $display("FAIL after_rst: valid/err=%b syn=%h required 11 0101",
               {syn_valid, err_detect}, syndromes);
    end
    @(negedge clk);
  endtask

  task automatic test_bubbles();
    send_frame(8'h01, 8'h01, 18, 1'b1, 1'b1);
    vectors++;
    if ({syn_valid, err_detect, syndromes} !== {2'b11, 16'h4F99}) begin
      miscompares++;
      $display("FAIL bubbles_a: valid/err=%b syn=%h required 11 4f99",
               {syn_valid, err_detect}, syndromes);
    end
    @(negedge clk);
    send_frame(8'h00, 8'h00, 18, 1'b1, 1'b1);
    vectors++;
    if ({syn_valid, err_detect, syndromes} !== {2'b10, 16'h0000}) begin
      miscompares++;
      $display("FAIL bubbles_b: valid/err=%b syn=%h required 10 0000",
               {syn_valid, err_detect}, syndromes);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_single_errors();
    test_backpressure();
    test_frame_err();
    test_rst_mid();
    test_bubbles();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
